exe_div_iter: RTL and testbench
===============================

EXE_DIV_ITER -- requirements
Module: exe_div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and result width in bits (legal values 8..64, powers of two).
REQ-002 SHALL have parameter TAG_W, default 8, width of the instruction tag carried through the unit.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port kill_i  input  1  flush; discards any in-flight or completed operation.
REQ-006 SHALL have port valid_i  input  1  request valid.
REQ-007 SHALL have port ready_o  output  1  unit can accept a request this cycle.
REQ-008 SHALL have port signed_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-009 SHALL have port rem_i  input  1  1 = return remainder, 0 = return quotient.
REQ-010 SHALL have port dividend_i  input  WIDTH  rs1 operand.
REQ-011 SHALL have port divisor_i  input  WIDTH  rs2 operand.
REQ-012 SHALL have port tag_i  input  TAG_W  request tag.
REQ-013 SHALL have port valid_o  output  1  result valid.
REQ-014 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-015 SHALL have port result_o  output  WIDTH  quotient or remainder.
REQ-016 SHALL have port tag_o  output  TAG_W  tag of the request producing result_o.
REQ-017 SHALL have port busy_o  output  1  high whenever state is not IDLE; used as exe-stage stall source.

Function
REQ-018 SHALL implement states IDLE, BUSY, DONE; ready_o = (state==IDLE) && !kill_i.
REQ-019 SHALL accept a request on a rising edge with valid_i && ready_o, capturing operand magnitudes, result signs, rem_i and tag_i; transition IDLE->BUSY.
REQ-020 SHALL perform one restoring radix-2 step per BUSY cycle using a log2(WIDTH)+1-bit counter; after WIDTH steps transition BUSY->DONE.
REQ-021 SHALL assert valid_o only in DONE; first valid cycle is WIDTH+1 cycles after the accept edge (65 for WIDTH=64).
REQ-022 SHALL hold result_o and tag_o stable while valid_o && !out_ready_i.
REQ-023 SHALL transition DONE->IDLE on valid_o && out_ready_i; ready_o rises the following cycle (no same-cycle re-accept).
REQ-024 SHALL apply quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend) when signed_i=1.
REQ-025 SHALL return, for divisor 0: quotient all-ones, remainder = dividend_i, for both signed and unsigned.
REQ-026 SHALL return, for signed most-negative / -1: quotient = most-negative value, remainder 0.
REQ-027 SHALL, on kill_i, go to IDLE on the next edge from any state, deassert valid_o, and ignore a coincident valid_i (kill has priority over accept and over out_ready_i).
REQ-028 SHALL drive result_o and tag_o to 0 whenever valid_o is 0.

Reset
REQ-029 SHALL, while rstn_i=0, force state IDLE, counter 0, all datapath registers 0; outputs ready_o=1 (absent kill), valid_o=0, busy_o=0, result_o=0, tag_o=0.
REQ-030 SHALL abandon an in-flight operation on reset assertion mid-BUSY or mid-DONE with no result emitted after release.

Configuration
REQ-031 SHALL provide macro DIV_EARLY_OUT_EN.
REQ-032 With DIV_EARLY_OUT_EN defined: divisor zero, signed overflow (REQ-026), or |dividend| < |divisor| SHALL go IDLE->DONE directly, valid_o in the cycle after accept (latency 1).
REQ-033 Without DIV_EARLY_OUT_EN: every operation, including those special cases, SHALL take the full WIDTH+1 latency with results per REQ-025/026.

Verification
REQ-034 WIDTH=64, unsigned, 100 / 7, rem_i=0 -> valid_o at cycle 65 after accept, result_o=14; rem_i=1 -> result_o=2.
REQ-035 Signed -20 / 3 -> quotient -6 (0xFFFF_FFFF_FFFF_FFFA); rem -> -2; tag_o equals tag_i of request.
REQ-036 Divisor 0, dividend 0x1234 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 0x1234; latency 1 with DIV_EARLY_OUT_EN, 65 without.
REQ-037 Signed 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
REQ-038 kill_i pulsed at BUSY step 30 with valid_i=1 same cycle -> no valid_o, ready_o=1 next cycle, new request accepted after.
REQ-039 Result held with out_ready_i=0 for 5 cycles -> result_o/tag_o stable; out_ready_i=1 -> IDLE, ready_o=1 one cycle later; rstn_i low mid-BUSY -> all outputs at reset values.

Source files
------------

// File: rtl/exe_div_iter.sv
// exe_div_iter: iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), WIDTH steps per op, macro DIV_EARLY_OUT_EN enables 1-cycle special cases; ports: clk_i, rstn_i, kill_i, valid_i/ready_o/signed_i/rem_i/dividend_i/divisor_i/tag_i in, valid_o/out_ready_i/result_o/tag_o out, busy_o
module exe_div_iter #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             kill_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             signed_i,
  input  logic             rem_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] quo, rem, dvs, a_mag, b_mag, res;
  logic [WIDTH:0] shifted, diff;
  logic neg_q, neg_r, rem_sel, a_neg, b_neg, dz, ge;
  logic [TAG_W-1:0] tag;
`ifdef DIV_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf;
  assign ovf = signed_i && dividend_i == MIN && divisor_i == '1;
`endif
  assign a_neg = signed_i & dividend_i[WIDTH-1];
  assign b_neg = signed_i & divisor_i[WIDTH-1];
  assign a_mag = a_neg ? -dividend_i : dividend_i;
  assign b_mag = b_neg ? -divisor_i : divisor_i;
  assign dz = divisor_i == '0;
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff = shifted - {1'b0, dvs};
  // a magnitude compare rather than the borrow bit keeps divide-by-zero exact (quotient all ones)
  assign ge = shifted >= {1'b0, dvs};
  assign ready_o = state == IDLE && !kill_i;
  assign valid_o = state == DONE;
  assign busy_o = state != IDLE;
  assign res = rem_sel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  assign result_o = valid_o ? res : '0;
  assign tag_o = valid_o ? tag : '0;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state <= IDLE;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rem_sel <= 1'b0;
      tag <= '0;
    end else if (kill_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          cnt <= '0;
          dvs <= b_mag;
          // divide-by-zero quotient stays all ones regardless of operand signs
          neg_q <= (a_neg ^ b_neg) & ~dz;
          neg_r <= a_neg;
          rem_sel <= rem_i;
          tag <= tag_i;
`ifdef DIV_EARLY_OUT_EN
          if (dz || ovf || a_mag < b_mag) begin
            state <= DONE;
            quo <= dz ? '1 : ovf ? MIN : '0;
            rem <= ovf ? '0 : a_mag;
          end else begin
            state <= BUSY;
            quo <= a_mag;
            rem <= '0;
          end
`else
          state <= BUSY;
          quo <= a_mag;
          rem <= '0;
`endif
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          quo <= {quo[WIDTH-2:0], ge};
          rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: if (out_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_exe_div_iter.sv
// tb_exe_div_iter: randomized and directed checks of exe_div_iter against an arithmetic reference model
module tb_exe_div_iter;
  localparam int W = 64;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  logic clk = 1'b0, rstn_i, kill_i, valid_i, ready_o, signed_i, rem_i, valid_o, out_ready_i, busy_o;
  logic [63:0] dividend_i, divisor_i, result_o;
  logic [7:0] tag_i, tag_o;
  int n_vec = 0, n_err = 0;

  exe_div_iter #(.WIDTH(W), .TAG_W(8)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .kill_i(kill_i), .valid_i(valid_i), .ready_o(ready_o),
    .signed_i(signed_i), .rem_i(rem_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .tag_i(tag_i), .valid_o(valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .tag_o(tag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(bit s, bit r, logic [63:0] a, logic [63:0] b);
    longint sa, sb;
    if (b == 64'd0) return r ? a : '1;
    if (s) begin
      if (a == MIN && b == '1) return r ? 64'd0 : MIN;
      sa = $signed(a);
      sb = $signed(b);
      return r ? 64'(sa % sb) : 64'(sa / sb);
    end
    return r ? a % b : a / b;
  endfunction

  function automatic int ref_lat(bit s, logic [63:0] a, logic [63:0] b);
    logic [63:0] am, bm;
    am = (s && a[63]) ? -a : a;
    bm = (s && b[63]) ? -b : b;
    if (EO && (b == 64'd0 || (s && a == MIN && b == '1) || am < bm)) return 1;
    return W + 1;
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
  endtask

  task automatic start_op(bit s, bit r, logic [63:0] a, logic [63:0] b, logic [7:0] t);
    @(negedge clk);
    chk("ready_idle", 64'(ready_o), 64'd1);
    signed_i = s; rem_i = r; dividend_i = a; divisor_i = b; tag_i = t; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic count_valid(int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      seen += int'(valid_o);
    end
  endtask

  task automatic do_op(bit s, bit r, logic [63:0] a, logic [63:0] b, logic [7:0] t, int hold);
    logic [63:0] exp;
    int lat, n;
    exp = ref_div(s, r, a, b);
    lat = ref_lat(s, a, b);
    n = 0;
    start_op(s, r, a, b, t);
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < 200);
    chk("latency", 64'(n), 64'(lat));
    chk("result", result_o, exp);
    chk("tag", 64'(tag_o), 64'(t));
    chk("ready_in_done", 64'(ready_o), 64'd0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 64'(valid_o), 64'd1);
      chk("hold_result", result_o, exp);
      chk("hold_tag", 64'(tag_o), 64'(t));
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk("release_valid", 64'(valid_o), 64'd0);
    chk("release_ready", 64'(ready_o), 64'd1);
    chk("release_busy", 64'(busy_o), 64'd0);
    chk("release_result", result_o, 64'd0);
  endtask

  initial begin
    int seen, n;
    logic [63:0] a, b;
    rstn_i = 1'b0; kill_i = 1'b0; valid_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0;
    dividend_i = '0; divisor_i = '0; tag_i = '0; out_ready_i = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    do_op(0, 0, 64'd100, 64'd7, 8'h11, 0);
    do_op(0, 1, 64'd100, 64'd7, 8'h12, 1);
    do_op(1, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 8'h21, 0);
    do_op(1, 1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 8'h22, 0);
    do_op(0, 0, 64'h1234, 64'd0, 8'h31, 0);
    do_op(0, 1, 64'h1234, 64'd0, 8'h32, 0);
    do_op(1, 0, 64'h1234, 64'd0, 8'h33, 0);
    do_op(1, 1, 64'hFFFF_FFFF_FFFF_EDCC, 64'd0, 8'h34, 0);
    do_op(1, 0, MIN, '1, 8'h41, 0);
    do_op(1, 1, MIN, '1, 8'h42, 0);
    do_op(0, 0, '1, 64'd3, 8'h51, 5);
    do_op(1, 1, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 8'h52, 0);
    for (int i = 0; i < 30; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 1000));
      case ($urandom_range(0, 3))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 255));
        2: b = {$urandom, $urandom};
        default: b = {{56{1'b1}}, 8'($urandom_range(0, 255))};
      endcase
      do_op(1'($urandom), 1'($urandom), a, b, 8'($urandom), int'($urandom_range(0, 3)));
    end
    start_op(0, 0, 64'd1000000, 64'd3, 8'h55);
    repeat (30) @(negedge clk);
    kill_i = 1'b1; valid_i = 1'b1; dividend_i = 64'd9; divisor_i = 64'd2; tag_i = 8'h66;
    #1 chk("kill_masks_ready", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1 kill_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("kill_valid", 64'(valid_o), 64'd0);
    chk("kill_ready", 64'(ready_o), 64'd1);
    chk("kill_busy", 64'(busy_o), 64'd0);
    count_valid(80, seen);
    chk("kill_no_result", 64'(seen), 64'd0);
    do_op(0, 0, 64'd81, 64'd9, 8'h67, 0);
    start_op(1, 0, 64'd123456789, 64'd1000, 8'h77);
    repeat (10) @(negedge clk);
    rstn_i = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rstn_i = 1'b1;
    count_valid(80, seen);
    chk("rst_busy_no_result", 64'(seen), 64'd0);
    start_op(0, 1, 64'd1000, 64'd7, 8'h78);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < 200);
    chk("done_before_rst", 64'(valid_o), 64'd1);
    rstn_i = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rstn_i = 1'b1;
    count_valid(10, seen);
    chk("rst_done_no_result", 64'(seen), 64'd0);
    do_op(0, 1, 64'd1000, 64'd7, 8'h79, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
